// File: rtl/wave_seq_ctrl.sv
// Burst sequencer for the 8-step waveform path: plays a captured pattern for reps periods.
// Outputs are registered (one edge from start to step 0); start is taken only in IDLE, hold freezes, abort cancels.
module wave_seq_ctrl #(
  parameter int REP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       pattern,
  input  logic [REP_W-1:0] reps,
  input  logic             a,
  input  logic             hold,
  input  logic             abort,
  output logic             out,
  output logic [2:0]       step,
  output logic [REP_W-1:0] reps_left,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [REP_W-1:0] ONE = REP_W'(1);

  state_t     state;
  logic [7:0] pat_q;
  logic [2:0] step_nx;
  logic       out_nx;

  // Level for the step being entered; step 7 is gated by the modulation input.
  always_comb begin
    step_nx = step + 3'd1;
    out_nx  = pat_q[step_nx];
    if (step_nx == 3'd7) out_nx = pat_q[7] & a;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pat_q     <= 8'd0;
      out       <= 1'b0;
      step      <= 3'd0;
      reps_left <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (reps != '0) begin
              state     <= RUN;
              pat_q     <= pattern;
              reps_left <= reps;
              step      <= 3'd0;
              out       <= pattern[0];
              busy      <= 1'b1;
            end else begin
              state <= DONE;
              done  <= 1'b1;
            end
          end
        end
        RUN, PAUSE: begin
          if (abort) begin
            state     <= IDLE;
            out       <= 1'b0;
            step      <= 3'd0;
            reps_left <= '0;
            busy      <= 1'b0;
          end else if (hold) begin
            state <= PAUSE;
          end else if (step == 3'd7) begin
            if (reps_left > ONE) begin
              state     <= RUN;
              step      <= 3'd0;
              out       <= pat_q[0];
              reps_left <= reps_left - ONE;
            end else begin
              state     <= DONE;
              out       <= 1'b0;
              step      <= 3'd0;
              reps_left <= '0;
              busy      <= 1'b0;
              done      <= 1'b1;
            end
          end else begin
            state <= RUN;
            step  <= step_nx;
            out   <= out_nx;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wave_seq_ctrl.sv
// Bench for wave_seq_ctrl: burst-position reference model checked every cycle, plus literal scenario checks.
module tb_wave_seq_ctrl;
  localparam int REP_W = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [7:0]       pattern;
  logic [REP_W-1:0] reps;
  logic             a;
  logic             hold;
  logic             abort;
  logic             out;
  logic [2:0]       step;
  logic [REP_W-1:0] reps_left;
  logic             busy;
  logic             done;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  wave_seq_ctrl #(.REP_W(REP_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pattern(pattern), .reps(reps),
    .a(a), .hold(hold), .abort(abort), .out(out), .step(step),
    .reps_left(reps_left), .busy(busy), .done(done)
  );

  // Reference: a burst is a count k of completed advances, 0 .. 8*reps-1.
  bit         m_active   = 1'b0;
  bit         m_done     = 1'b0;
  bit         m_was_done = 1'b0;
  bit         m_a7       = 1'b0;
  int         m_k        = 0;
  int         m_reps     = 0;
  logic [7:0] m_pat      = 8'd0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_done = 1'b0; m_k = 0; m_reps = 0; m_pat = 8'd0; m_a7 = 1'b0;
    end else begin
      m_was_done = m_done;
      m_done     = 1'b0;
      if (m_active) begin
        if (abort) m_active = 1'b0;
        else if (!hold) begin
          m_k++;
          if (m_k == 8 * m_reps) begin
            m_active = 1'b0;
            m_done   = 1'b1;
          end else if (m_k % 8 == 7) begin
            m_a7 = a;
          end
        end
      end else if (!m_was_done && start) begin
        if (reps == '0) m_done = 1'b1;
        else begin
          m_active = 1'b1; m_k = 0; m_pat = pattern; m_reps = int'(reps);
        end
      end
    end
  end

  function automatic logic [31:0] exp_step();
    return m_active ? 32'(m_k % 8) : 32'd0;
  endfunction

  function automatic logic [31:0] exp_out();
    if (!m_active) return 32'd0;
    if (m_k % 8 == 7) return 32'(m_pat[7] & m_a7);
    return 32'(m_pat[m_k % 8]);
  endfunction

  function automatic logic [31:0] exp_reps_left();
    return m_active ? 32'(m_reps - m_k / 8) : 32'd0;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_out",       32'(out),       exp_out());
      chk("model_step",      32'(step),      exp_step());
      chk("model_reps_left", 32'(reps_left), exp_reps_left());
      chk("model_busy",      32'(busy),      32'(m_active));
      chk("model_done",      32'(done),      32'(m_done));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Present a start for one edge, then scramble pattern/reps to show they are not re-sampled.
  task automatic go(input logic [7:0] p, input logic [REP_W-1:0] r);
    pattern = p; reps = r; start = 1'b1;
    tick();
    start = 1'b0; pattern = 8'($urandom); reps = REP_W'($urandom);
  endtask

  logic [7:0] seq;
  int         held;
  int         dc;

  initial begin
    rst_n = 1'b0; start = 1'b0; pattern = 8'd0; reps = '0;
    a = 1'b0; hold = 1'b0; abort = 1'b0;
    repeat (2) tick();
    chk("reset_out", 32'(out), 32'd0);
    chk("reset_step", 32'(step), 32'd0);
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_done", 32'(done), 32'd0);
    rst_n = 1'b1;
    chk_en = 1'b1;
    repeat (2) tick();

    // Single burst, one period.
    a = 1'b1;
    go(8'b1011_0010, REP_W'(1));
    seq = 8'd0;
    for (int i = 0; i < 8; i++) begin
      seq[i] = out;
      chk("burst1_step", 32'(step), 32'(i));
      chk("burst1_busy", 32'(busy), 32'd1);
      tick();
    end
    chk("burst1_out_seq", 32'(seq), 32'h0000_00B2);
    chk("burst1_done", 32'(done), 32'd1);
    chk("burst1_busy_end", 32'(busy), 32'd0);
    tick();
    chk("burst1_done_clear", 32'(done), 32'd0);
    repeat (2) tick();

    // Modulation gates step 7 per period; reps_left counts down at the wrap.
    a = 1'b0;
    go(8'h80, REP_W'(2));
    for (int i = 0; i < 16; i++) begin
      if (i == 0)  chk("mod_reps_left_p1", 32'(reps_left), 32'd2);
      if (i == 8)  chk("mod_reps_left_p2", 32'(reps_left), 32'd1);
      if (i == 7)  chk("mod_out_step7_p1", 32'(out), 32'd0);
      if (i == 15) chk("mod_out_step7_p2", 32'(out), 32'd1);
      if (i == 8)  a = 1'b1;
      tick();
    end
    chk("mod_done", 32'(done), 32'd1);
    repeat (2) tick();

    // Hold for three edges starting at step 2.
    go(8'h55, REP_W'(1));
    held = 0; dc = -1;
    for (int n = 0; n < 30 && dc < 0; n++) begin
      if (busy && step == 3'd2 && out) held++;
      if (done) dc = n;
      hold = (n >= 2 && n <= 4);
      tick();
    end
    hold = 1'b0;
    chk("hold_cycles_at_step2", 32'(held), 32'd4);
    chk("hold_done_cycle", 32'(dc), 32'd11);
    repeat (2) tick();

    // Abort together with hold at the final step 7.
    a = 1'b1;
    go(8'($urandom), REP_W'(2));
    for (int n = 0; n < 15; n++) tick();
    chk("abort_pre_step", 32'(step), 32'd7);
    chk("abort_pre_reps_left", 32'(reps_left), 32'd1);
    abort = 1'b1; hold = 1'b1;
    tick();
    abort = 1'b0; hold = 1'b0;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_out", 32'(out), 32'd0);
    chk("abort_step", 32'(step), 32'd0);
    chk("abort_reps_left", 32'(reps_left), 32'd0);
    for (int n = 0; n < 4; n++) begin
      chk("abort_no_done", 32'(done), 32'd0);
      tick();
    end

    // Zero repeat count completes immediately.
    go(8'hFF, REP_W'(0));
    chk("zero_reps_done", 32'(done), 32'd1);
    chk("zero_reps_busy", 32'(busy), 32'd0);
    tick();
    chk("zero_reps_done_clear", 32'(done), 32'd0);
    chk("zero_reps_busy_after", 32'(busy), 32'd0);
    repeat (2) tick();

    // Start re-asserted while running is ignored.
    go(8'hFF, REP_W'(1));
    start = 1'b1; reps = REP_W'(5);
    dc = -1;
    for (int n = 0; n < 30 && dc < 0; n++) begin
      if (done) dc = n;
      if (n == 4) start = 1'b0;
      tick();
    end
    chk("start_in_run_done_cycle", 32'(dc), 32'd8);
    repeat (2) tick();

    // Asynchronous reset in the middle of a burst.
    go(8'hFF, REP_W'(3));
    repeat (4) tick();
    chk("midreset_pre_step", 32'(step), 32'd4);
    chk("midreset_pre_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_out", 32'(out), 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    chk("midreset_step", 32'(step), 32'd0);
    chk("midreset_reps_left", 32'(reps_left), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    go(8'h01, REP_W'(1));
    chk("restart_out", 32'(out), 32'd1);
    chk("restart_busy", 32'(busy), 32'd1);
    repeat (10) tick();

    // Random traffic against the reference.
    for (int n = 0; n < 3000; n++) begin
      start   = ($urandom_range(0, 3) == 0);
      pattern = 8'($urandom);
      reps    = REP_W'($urandom_range(0, 4));
      a       = 1'($urandom);
      hold    = ($urandom_range(0, 4) == 0);
      abort   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        #1;
        chk("rand_async_reset_busy", 32'(busy), 32'd0);
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    start = 1'b0; hold = 1'b0; abort = 1'b0;
    repeat (3) tick();
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
